// File: rtl/feistel_pkg.sv
// Shared types and default sizes for the Feistel decrypt controller slice.
// Optional watchdog is enabled by defining FEISTEL_CTRL_WDOG_EN.
package feistel_pkg;

  localparam int DEF_DATA_WIDTH  = 256;
  localparam int DEF_KEY_SIZE    = 128;
  localparam int DEF_SBOX_WIDTH  = 8;
  localparam int DEF_SBOX_DEPTH  = 256;
  localparam int DEF_OFIFO_DEPTH = 64;
  localparam int DEF_NBLK_W      = 32;
  localparam int DEF_WDOG_CYCLES = 1024;
  localparam int NUM_ROUNDS      = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_SBOX = 3'd1,
    ST_LOAD_KEY  = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } feistel_ctrl_state_t;

endpackage

// File: rtl/feistel_ofifo.sv
// Synchronous show-ahead FIFO holding core results; head_o is zero while empty.
module feistel_ofifo #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   head_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the count gates everything visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/feistel_ctrl.sv
// Sequencer and credit-based flow controller for the pipelined Feistel decrypt core.
// Define FEISTEL_CTRL_WDOG_EN to build the lost-result watchdog.
module feistel_ctrl
  import feistel_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KEY_SIZE    = DEF_KEY_SIZE,
  parameter int SBOX_WIDTH  = DEF_SBOX_WIDTH,
  parameter int SBOX_DEPTH  = DEF_SBOX_DEPTH,
  parameter int OFIFO_DEPTH = DEF_OFIFO_DEPTH,
  parameter int NBLK_W      = DEF_NBLK_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cfg_start,
  input  logic [NBLK_W-1:0]              cfg_nblocks,
  input  logic [KEY_SIZE-1:0]            cfg_k0,
  input  logic [KEY_SIZE-1:0]            cfg_k1,
  input  logic [KEY_SIZE-1:0]            cfg_k2,
  input  logic [KEY_SIZE-1:0]            cfg_k3,
  input  logic [KEY_SIZE-1:0]            cfg_k4,
  input  logic                           sbox_in_valid,
  output logic                           sbox_in_ready,
  input  logic [SBOX_WIDTH-1:0]          sbox_in_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [SBOX_WIDTH-1:0]          core_sbox_out,
  output logic                           core_sbox_valid,
  output logic                           core_key_valid,
  output logic [KEY_SIZE-1:0]            core_K0,
  output logic [KEY_SIZE-1:0]            core_K1,
  output logic [KEY_SIZE-1:0]            core_K2,
  output logic [KEY_SIZE-1:0]            core_K3,
  output logic [KEY_SIZE-1:0]            core_K4,
  output logic                           core_tvalid,
  output logic [DATA_WIDTH-1:0]          core_ciphertext,
  input  logic                           core_valid,
  input  logic [DATA_WIDTH-1:0]          core_plaintext,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output feistel_ctrl_state_t            dbg_state,
  output logic [$clog2(OFIFO_DEPTH):0]   dbg_inflight,
  output logic [$clog2(OFIFO_DEPTH):0]   dbg_fifo_count
);

  // Handshakes: a beat transfers on a cycle where valid && ready are both high
  // at the rising clock edge; valid must not depend on ready.

  localparam int CNT_W  = $clog2(OFIFO_DEPTH) + 1;
  localparam int SCNT_W = $clog2(SBOX_DEPTH) + 1;

  feistel_ctrl_state_t   state_q, state_d;
  logic [NBLK_W-1:0]     blk_left_q, blk_left_d;
  logic [SCNT_W-1:0]     sbox_cnt_q, sbox_cnt_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  err_q, err_d;
  logic [KEY_SIZE-1:0]   key_q [NUM_ROUNDS];
  logic [SBOX_WIDTH-1:0] sbox_out_q;
  logic                  sbox_valid_q;
  logic [DATA_WIDTH-1:0] ct_q;
  logic                  tvalid_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [CNT_W:0]        credit_used;
  logic                  start_acc, sbox_hs, s_hs, m_hs;
  logic                  ret_ok, ret_spurious, wdog_fire, drain_done;

  assign start_acc    = cfg_start && (state_q == ST_IDLE);
  assign sbox_hs      = sbox_in_valid && sbox_in_ready;
  assign s_hs         = s_valid && s_ready;
  assign m_hs         = m_valid && m_ready;
  assign ret_ok       = core_valid && (inflight_q != '0);
  assign ret_spurious = core_valid && (inflight_q == '0);
  // Every issued block owns a FIFO slot until popped, so the FIFO never overflows.
  assign credit_used  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign drain_done   = (state_q == ST_DRAIN) && (inflight_q == '0) && fifo_empty;

`ifdef FEISTEL_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if ((inflight_q == '0) || core_valid || wdog_fire) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_fire = (wdog_q == WDOG_W'(WDOG_CYCLES));
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (cfg_start) state_d = ST_LOAD_SBOX;
      ST_LOAD_SBOX: if (sbox_hs && (sbox_cnt_q == SCNT_W'(SBOX_DEPTH - 1))) state_d = ST_LOAD_KEY;
      ST_LOAD_KEY:  state_d = (blk_left_q == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:       if ((blk_left_q == '0) || (s_hs && (blk_left_q == NBLK_W'(1)))) state_d = ST_DRAIN;
      ST_DRAIN:     if (drain_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (wdog_fire) state_d = ST_IDLE;
  end

  always_comb begin
    busy           = (state_q != ST_IDLE);
    sbox_in_ready  = (state_q == ST_LOAD_SBOX);
    core_key_valid = (state_q == ST_LOAD_KEY) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    s_ready        = (state_q == ST_RUN) && (blk_left_q != '0) &&
                     (credit_used < (CNT_W+1)'(OFIFO_DEPTH));
    done           = drain_done || wdog_fire;
  end

  always_comb begin
    blk_left_d = blk_left_q;
    if (start_acc)  blk_left_d = cfg_nblocks;
    else if (s_hs)  blk_left_d = blk_left_q - 1'b1;

    sbox_cnt_d = sbox_cnt_q;
    if (start_acc)    sbox_cnt_d = '0;
    else if (sbox_hs) sbox_cnt_d = sbox_cnt_q + 1'b1;

    inflight_d = inflight_q;
    case ({s_hs, ret_ok})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    if (wdog_fire) inflight_d = '0;

    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (ret_spurious || wdog_fire) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_left_q   <= '0;
      sbox_cnt_q   <= '0;
      inflight_q   <= '0;
      err_q        <= 1'b0;
      sbox_out_q   <= '0;
      sbox_valid_q <= 1'b0;
      ct_q         <= '0;
      tvalid_q     <= 1'b0;
      for (int r = 0; r < NUM_ROUNDS; r++) key_q[r] <= '0;
    end else begin
      blk_left_q   <= blk_left_d;
      sbox_cnt_q   <= sbox_cnt_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
      sbox_valid_q <= sbox_hs;
      tvalid_q     <= s_hs;
      if (sbox_hs) sbox_out_q <= sbox_in_data;
      if (s_hs)    ct_q       <= s_data;
      if (start_acc) begin
        key_q[0] <= cfg_k0;
        key_q[1] <= cfg_k1;
        key_q[2] <= cfg_k2;
        key_q[3] <= cfg_k3;
        key_q[4] <= cfg_k4;
      end
    end
  end

  feistel_ofifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OFIFO_DEPTH)
  ) u_ofifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (wdog_fire),
    .push_i      (ret_ok),
    .push_data_i (core_plaintext),
    .pop_i       (m_hs),
    .head_o      (m_data),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign m_valid         = !fifo_empty;
  assign core_sbox_out   = sbox_out_q;
  assign core_sbox_valid = sbox_valid_q;
  assign core_tvalid     = tvalid_q;
  assign core_ciphertext = ct_q;
  assign core_K0         = key_q[0];
  assign core_K1         = key_q[1];
  assign core_K2         = key_q[2];
  assign core_K3         = key_q[3];
  assign core_K4         = key_q[4];
  assign err             = err_q;
  assign dbg_state       = state_q;
  assign dbg_inflight    = inflight_q;
  assign dbg_fifo_count  = fifo_count;

endmodule
